grid_scan_driver: RTL and testbench
===================================

// Module: grid_scan_driver
// PURPOSE
//  Display-side reader for the 64-bit Game of Life grid output (8x8, bit 8*r+c = row r, col c).
//  - Snapshots the grid once per frame.
//  - Row-scans the snapshot onto an 8x8 LED matrix with an inter-row blanking gap.
//  - Every FRAMES_PER_GEN frames, emits a one-cycle gen_tick that paces the grid's evolution step.
//  Sits between the grid output and the board matrix pins.
// PARAMETERS
//  DWELL_CYCLES    50000  cycles each row is driven (>=1)
//  BLANK_CYCLES    500    cycles of all-off before each row (>=1)
//  FRAMES_PER_GEN  60     full frames per generation tick (>=1)
//  GEN_W           16     width of generation counter
// PORTS
//  clk           in   1      system clock; only clock in the block
//  flopreset_n   in   1      asynchronous, active-low reset
//  run           in   1      1 = generate gen_tick; 0 = hold evolution
//  grid_in       in   64     live grid from the game core
//  row_sel       out  8      one-hot row enable, active-high; 0 during blank
//  col_data      out  8      column bits of the active row; 0 during blank
//  frame_start   out  1      1-cycle pulse: first DRIVE cycle of row 0
//  gen_tick      out  1      1-cycle evolution enable pulse
//  gen_count     out  GEN_W  generations ticked so far; wraps to 0
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (asynchronous assert, synchronous release):
//    - state=BLANK, row=0, all counters 0, snapshot=0.
//    - row_sel, col_data, frame_start, gen_tick and gen_count all 0.
//  - FSM:
//    - BLANK: count BLANK_CYCLES, then go to DRIVE for the current row.
//    - DRIVE: count DWELL_CYCLES, then row <= row+1 (7 wraps to 0) and go to BLANK.
//  - Timing:
//    - Row period = BLANK_CYCLES + DWELL_CYCLES.
//    - Frame period = 8 * row period.
//    - After reset release, the first frame_start occurs in cycle BLANK_CYCLES (0-based).
//  - Snapshot:
//    - On the edge entering DRIVE for row 0: snapshot <= grid_in and frame_start <= 1.
//    - grid_in changes at any other time are invisible until the next frame.
//  - During DRIVE of row r: row_sel = 1<<r and col_data = snapshot[8r+7:8r].
//    - Both change together on the same edge.
//  - Frame counter: increments at each frame_start while run=1.
//    - When it reaches FRAMES_PER_GEN, gen_tick=1 for exactly the frame_start cycle.
//    - At the same time the frame counter is cleared and gen_count increments (wraps).
//  - Tick ordering: the snapshot taken in a gen_tick cycle holds the pre-tick generation.
//    - The new generation appears on the next frame.
//  - run=0: frame counter held at 0, gen_tick=0, gen_count holds.
//    - Scanning continues regardless of run.
//  - run rising mid-frame: counting starts at the next frame_start; no partial-frame credit.
//  - Reset mid-row:
//    - Outputs go to 0 immediately.
//    - After release, the scan restarts at BLANK/row 0 with no residual tick.
//  - Counter widths: $clog2(max(DWELL,BLANK)+1) for the dwell timer; $clog2(FRAMES_PER_GEN+1) for the frame counter.
//  - Parameter violations (<1): $error at elaboration.
// STRUCTURE
//  - Package gol_display_pkg:
//    - GRID_DIM=8 and GRID_BITS=64 localparams.
//    - typedef enum logic {BLANK, DRIVE} scan_state_t.
//    - function row_slice(grid, r) returning 8 bits.
//  - Sub-module scan_timer: loadable down-counter with terminal-count flag.
//    - Instantiated once, reloaded with BLANK_CYCLES or DWELL_CYCLES on each state change.
//  - Top level holds: FSM, row counter, snapshot register, frame/gen counters, output registers.
// TESTING (DWELL_CYCLES=4, BLANK_CYCLES=2, FRAMES_PER_GEN=3, GEN_W=2 unless stated)
//  1. Reset held, then released at cycle 0.
//     -> All outputs 0 during reset.
//     -> At cycle 2: frame_start=1, row_sel=8'h01.
//  2. grid_in=64'h8040_2010_0804_0201.
//     -> col_data in successive rows is 01,02,04,08,10,20,40,80, each for 4 cycles.
//     -> 2-cycle gaps with row_sel=0 and col_data=0 between rows.
//     -> frame_start every 48 cycles.
//  3. grid_in changed to all-ones during row 3.
//     -> Rows 3..7 still show the old data.
//     -> col_data=8'hFF from the next frame_start onward.
//  4. run=1 from reset.
//     -> gen_tick on every 3rd frame_start (every 144 cycles).
//     -> gen_count goes 1,2,3,0 (wrap).
//     -> run=0 -> no gen_tick and gen_count holds while scanning continues.
//  5. flopreset_n pulsed low during DRIVE of row 5.
//     -> Same cycle: row_sel=0, col_data=0, gen_count=0.
//     -> After release: frame_start 2 cycles later with row_sel=8'h01.
//  6. run raised 10 cycles after a frame_start.
//     -> First gen_tick occurs at the 3rd subsequent frame_start, not earlier.

Source files
------------

// File: rtl/grid_scan_driver_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gol_display_pkg : shared types and helpers for the grid display   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package gol_display_pkg;

    localparam int GRID_DIM  = 8;
    localparam int GRID_BITS = GRID_DIM * GRID_DIM;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    function automatic logic [GRID_DIM-1:0] row_slice(
        input logic [GRID_BITS-1:0] grid,
        input logic [2:0]           r
    );
        return grid[GRID_DIM*r +: GRID_DIM];
    endfunction

endpackage
`default_nettype wire

// File: rtl/grid_scan_driver_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | grid_scan_driver_if : grid input / LED matrix output bundle       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface grid_scan_driver_if #(
    parameter int GEN_W = 16
);
    import gol_display_pkg::*;

    logic                  run;
    logic [GRID_BITS-1:0]  grid_in;
    logic [GRID_DIM-1:0]   row_sel;
    logic [GRID_DIM-1:0]   col_data;
    logic                  frame_start;
    logic                  gen_tick;
    logic [GEN_W-1:0]      gen_count;

    modport master (
        output run, grid_in,
        input  row_sel, col_data, frame_start, gen_tick, gen_count
    );

    modport slave (
        input  run, grid_in,
        output row_sel, col_data, frame_start, gen_tick, gen_count
    );

endinterface
`default_nettype wire

// File: rtl/grid_scan_driver_scan_timer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scan_timer : loadable down-counter, tc high when it reaches zero  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module scan_timer #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  wire logic             clk,
    input  wire logic             flopreset_n,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    output logic                  tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge flopreset_n) begin
        if (!flopreset_n) begin
            r_count <= INIT;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/grid_scan_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | grid_scan_driver : row-scans a 64-bit Life grid onto an 8x8 LED   |
// | matrix and paces generations with gen_tick.          Rev 1.0      |
// +------------------------------------------------------------------+
module grid_scan_driver
    import gol_display_pkg::*;
#(
    parameter int DWELL_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int FRAMES_PER_GEN = 60,
    parameter int GEN_W          = 16
) (
    input  wire logic         clk,
    input  wire logic         flopreset_n,
    grid_scan_driver_if.slave bus
);

    localparam int c_MAX_SPAN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int c_TMR_W    = $clog2(c_MAX_SPAN + 1);
    localparam int c_FRM_W    = $clog2(FRAMES_PER_GEN + 1);
    localparam logic [c_TMR_W-1:0] c_DWELL_LOAD = c_TMR_W'(DWELL_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_BLANK_LOAD = c_TMR_W'(BLANK_CYCLES - 1);
    localparam logic [c_FRM_W-1:0] c_FRM_LAST   = c_FRM_W'(FRAMES_PER_GEN);

    if (DWELL_CYCLES < 1) begin : g_chk_dwell
        $error("grid_scan_driver: DWELL_CYCLES must be >= 1");
    end
    if (BLANK_CYCLES < 1) begin : g_chk_blank
        $error("grid_scan_driver: BLANK_CYCLES must be >= 1");
    end
    if (FRAMES_PER_GEN < 1) begin : g_chk_frames
        $error("grid_scan_driver: FRAMES_PER_GEN must be >= 1");
    end

    scan_state_t          r_state, w_state_nxt;
    logic [2:0]           r_row, w_row_nxt;
    logic                 w_tc;
    logic                 w_frame_edge;
    logic                 w_tick;
    logic [GRID_BITS-1:0] r_snapshot;
    logic [c_FRM_W-1:0]   r_frame_cnt;
    logic [GEN_W-1:0]     r_gen_count;
    logic [GRID_DIM-1:0]  r_row_sel, r_col_data;
    logic [GRID_DIM-1:0]  w_row_sel_nxt, w_col_data_nxt;
    logic                 r_frame_start, r_gen_tick;

    // Reset preloads the first blank interval so row 0 lights BLANK_CYCLES after release.
    scan_timer #(
        .WIDTH (c_TMR_W),
        .INIT  (c_BLANK_LOAD)
    ) u_scan_timer (
        .clk         (clk),
        .flopreset_n (flopreset_n),
        .load        (w_tc),
        .load_val    ((r_state == BLANK) ? c_DWELL_LOAD : c_BLANK_LOAD),
        .tc          (w_tc)
    );

    always_ff @(posedge clk or negedge flopreset_n) begin
        if (!flopreset_n) begin
            r_state <= BLANK;
            r_row   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        if (w_tc) begin
            if (r_state == BLANK) begin
                w_state_nxt = DRIVE;
            end else begin
                w_state_nxt = BLANK;
                w_row_nxt   = r_row + 3'd1;
            end
        end
    end

    assign w_frame_edge = w_tc && (r_state == BLANK) && (r_row == 3'd0);
    assign w_tick       = w_frame_edge && bus.run &&
                          ((r_frame_cnt + c_FRM_W'(1)) == c_FRM_LAST);

    // On the frame edge the snapshot is loaded this same edge, so row 0 reads grid_in directly.
    always_comb begin
        w_row_sel_nxt  = '0;
        w_col_data_nxt = '0;
        if (w_state_nxt == DRIVE) begin
            w_row_sel_nxt  = GRID_DIM'(1) << w_row_nxt;
            w_col_data_nxt = row_slice(w_frame_edge ? bus.grid_in : r_snapshot, w_row_nxt);
        end
    end

    always_ff @(posedge clk or negedge flopreset_n) begin
        if (!flopreset_n) begin
            r_snapshot    <= '0;
            r_frame_cnt   <= '0;
            r_gen_count   <= '0;
            r_row_sel     <= '0;
            r_col_data    <= '0;
            r_frame_start <= 1'b0;
            r_gen_tick    <= 1'b0;
        end else begin
            if (w_frame_edge) begin
                r_snapshot <= bus.grid_in;
            end
            // Any cycle with run low discards partial-frame credit.
            if (!bus.run) begin
                r_frame_cnt <= '0;
            end else if (w_frame_edge) begin
                r_frame_cnt <= w_tick ? '0 : r_frame_cnt + c_FRM_W'(1);
            end
            if (w_tick) begin
                r_gen_count <= r_gen_count + GEN_W'(1);
            end
            r_row_sel     <= w_row_sel_nxt;
            r_col_data    <= w_col_data_nxt;
            r_frame_start <= w_frame_edge;
            r_gen_tick    <= w_tick;
        end
    end

    assign bus.row_sel     = r_row_sel;
    assign bus.col_data    = r_col_data;
    assign bus.frame_start = r_frame_start;
    assign bus.gen_tick    = r_gen_tick;
    assign bus.gen_count   = r_gen_count;

endmodule
`default_nettype wire

// File: tb/tb_grid_scan_driver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_grid_scan_driver : randomized bench with a cycle-position model|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_grid_scan_driver;
    import gol_display_pkg::*;

    localparam int D      = 4;
    localparam int B      = 2;
    localparam int F      = 3;
    localparam int GW     = 2;
    localparam int ROWP   = B + D;
    localparam int FRAMEP = GRID_DIM * ROWP;
    localparam logic [63:0] DIAG = 64'h8040_2010_0804_0201;

    logic clk         = 1'b0;
    logic flopreset_n = 1'b0;

    grid_scan_driver_if #(.GEN_W(GW)) bus ();

    grid_scan_driver #(
        .DWELL_CYCLES   (D),
        .BLANK_CYCLES   (B),
        .FRAMES_PER_GEN (F),
        .GEN_W          (GW)
    ) dut (
        .clk         (clk),
        .flopreset_n (flopreset_n),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    int          k          = 0;
    int          fs_k       = 0;
    logic [63:0] m_snap     = '0;
    int          m_cnt      = 0;
    int          m_gen      = 0;
    bit          m_tick     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, k);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_row_sel"},     64'(bus.row_sel),     64'd0);
        check({tag, "_col_data"},    64'(bus.col_data),    64'd0);
        check({tag, "_frame_start"}, 64'(bus.frame_start), 64'd0);
        check({tag, "_gen_tick"},    64'(bus.gen_tick),    64'd0);
        check({tag, "_gen_count"},   64'(bus.gen_count),   64'd0);
    endtask

    task automatic model_reset();
        k      = 0;
        m_snap = '0;
        m_cnt  = 0;
        m_gen  = 0;
        m_tick = 1'b0;
    endtask

    // Expected outputs follow from where cycle k falls inside the 48-cycle frame.
    task automatic check_model();
        int         pos;
        int         row;
        bit         drv;
        logic [7:0] e_rs;
        logic [7:0] e_cd;
        pos  = k % FRAMEP;
        row  = pos / ROWP;
        drv  = (pos % ROWP) >= B;
        e_rs = drv ? 8'(1 << row) : 8'h00;
        e_cd = drv ? m_snap[8*row +: 8] : 8'h00;
        check("row_sel",     64'(bus.row_sel),     64'(e_rs));
        check("col_data",    64'(bus.col_data),    64'(e_cd));
        check("frame_start", 64'(bus.frame_start), 64'(pos == B));
        check("gen_tick",    64'(bus.gen_tick),    64'(m_tick));
        check("gen_count",   64'(bus.gen_count),   64'(m_gen));
    endtask

    task automatic step();
        logic        run_s;
        logic [63:0] g_s;
        run_s = bus.run;
        g_s   = bus.grid_in;
        @(posedge clk);
        #1;
        k++;
        m_tick = 1'b0;
        if (!run_s) m_cnt = 0;
        if (k % FRAMEP == B) begin
            m_snap = g_s;
            if (run_s) begin
                m_cnt++;
                if (m_cnt == F) begin
                    m_tick = 1'b1;
                    m_cnt  = 0;
                    m_gen  = (m_gen + 1) % (1 << GW);
                end
            end
        end
        check_model();
    endtask

    initial begin
        bus.run     = 1'b1;
        bus.grid_in = DIAG;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        flopreset_n = 1'b1;

        // Twelve frames: diagonal pattern, grid swapped to all-ones during row 3 of frame 1.
        for (int i = 0; i < 12*FRAMEP; i++) begin
            if (k == FRAMEP + B + 3*ROWP + 1) bus.grid_in = '1;
            step();
            if (k == B) begin
                check("first_fs_lit", 64'(bus.frame_start), 64'd1);
                check("first_rs_lit", 64'(bus.row_sel),     64'h01);
            end
            if (k == B + 3*ROWP)          check("row3_lit",     64'(bus.col_data), 64'h08);
            if (k == FRAMEP + B + 7*ROWP) check("old_row7_lit", 64'(bus.col_data), 64'h80);
            if (k == 2*FRAMEP + B) begin
                check("new_frame_ff_lit", 64'(bus.col_data),  64'hFF);
                check("tick1_lit",        64'(bus.gen_tick),  64'd1);
                check("gen1_lit",         64'(bus.gen_count), 64'd1);
            end
            if (k == 11*FRAMEP + B) begin
                check("tick4_lit", 64'(bus.gen_tick),  64'd1);
                check("wrap_lit",  64'(bus.gen_count), 64'd0);
            end
        end

        // Evolution held: scanning continues, generation frozen.
        bus.run = 1'b0;
        for (int i = 0; i < 4*FRAMEP; i++) begin
            if ($urandom_range(0, 5) == 0) bus.grid_in = {$urandom, $urandom};
            step();
        end
        check("hold_gen_lit", 64'(bus.gen_count), 64'd0);

        // run rises 10 cycles after a frame_start: no partial-frame credit.
        for (int i = 0; i < FRAMEP && (k % FRAMEP != B); i++) step();
        fs_k = k;
        repeat (10) step();
        bus.run = 1'b1;
        for (int i = 0; i < 3*FRAMEP; i++) begin
            step();
            if (k == fs_k + 3*FRAMEP)  check("late_run_tick_lit", 64'(bus.gen_tick), 64'd1);
            else if (k % FRAMEP == B)  check("no_early_tick_lit", 64'(bus.gen_tick), 64'd0);
        end

        // Random grid and run activity.
        for (int i = 0; i < 10*FRAMEP; i++) begin
            if ($urandom_range(0, 6) == 0)  bus.grid_in = {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) bus.run = ~bus.run;
            step();
        end

        // Asynchronous reset during DRIVE of row 5.
        bus.run = 1'b1;
        for (int i = 0; i < FRAMEP && (k % FRAMEP != B + 5*ROWP + 1); i++) step();
        check("row5_active_lit", 64'(bus.row_sel), 64'h20);
        flopreset_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("reset_hold");
        flopreset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6*FRAMEP; i++) begin
            if ($urandom_range(0, 6) == 0) bus.grid_in = {$urandom, $urandom};
            step();
            if (k == B) begin
                check("restart_fs_lit", 64'(bus.frame_start), 64'd1);
                check("restart_rs_lit", 64'(bus.row_sel),     64'h01);
                check("restart_tick_lit", 64'(bus.gen_tick),  64'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
